uart_receiver: RTL

UART serial receiver with an integrated first-word-fall-through (FWFT) receive FIFO. It sits directly upstream of the UART/7-segment control block.
- Deserialises 8N1 frames from the `rx` pin.
- Exposes received bytes through `uart_rx_fifo_data` / `_read` / `_full` / `_empty`.
- The control block latches `uart_rx_fifo_data` in the same cycle it asserts `uart_rx_fifo_read`, so the FIFO output must be show-ahead.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/uart_receiver.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared receiver definitions: FSM states, oversampling constants and the
// baud tick divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;
  localparam int DATA_BITS  = 8;

  // Clocks per oversample tick, floored at 1 so very slow clocks still tick.
  function automatic int calc_tick_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * OVERSAMPLE);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: pop_data is the head entry whenever empty=0.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Handshake: pop is honoured only while empty=0; push is accepted while
  // full=0, or while full when a pop frees the head slot in the same cycle.
  // A push that cannot be accepted raises overflow for that cycle and is lost.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & ~do_push;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority voting and a
// show-ahead receive FIFO feeding the control block.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] uart_rx_fifo_data,
  input  logic       uart_rx_fifo_read,
  output logic       uart_rx_fifo_full,
  output logic       uart_rx_fifo_empty,
  output logic       frame_error,
  output logic       overrun,
  output rx_state_e  dbg_state
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  rx_state_e        state, state_next;
  logic             sync1, sync2, rx_prev;
  logic [1:0]       settle_cnt;
  logic             armed;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             s_lo, s_mid;
  logic             start_edge, vote;
  logic             at_lo, at_mid, at_hi;
  logic             push, fe_cond, shift_en, clr_ticks;
  logic             fifo_overflow;

  assign tick  = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign at_lo  = tick && (tick_cnt == 4'(SAMPLE_LO - 1));
  assign at_mid = tick && (tick_cnt == 4'(SAMPLE_MID - 1));
  assign at_hi  = tick && (tick_cnt == 4'(SAMPLE_HI - 1));
  assign vote   = (s_lo & s_mid) | (s_lo & sync2) | (s_mid & sync2);
  // armed only once the line has been seen high through real synchronised data,
  // so a line held low across reset never looks like a start edge.
  assign start_edge = armed & rx_prev & ~sync2;
  assign dbg_state  = state;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    fe_cond    = 1'b0;
    shift_en   = 1'b0;
    clr_ticks  = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_next = START;
          clr_ticks  = 1'b1;
        end
      end
      START: begin
        if (at_hi) state_next = vote ? IDLE : DATA;
      end
      DATA: begin
        if (at_hi) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state_next = STOP;
        end
      end
      STOP: begin
        if (at_hi) begin
          if (vote) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            fe_cond    = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (sync2) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The tick count runs freely across bit windows; each 16-tick wrap opens the
  // next window, so every bit is voted at ticks 7/8/9 of its own window.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      rx_prev     <= 1'b1;
      settle_cnt  <= '0;
      armed       <= 1'b0;
      div_cnt     <= '0;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      s_lo        <= 1'b1;
      s_mid       <= 1'b1;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
      if (settle_cnt != 2'd2) settle_cnt <= settle_cnt + 2'd1;
      if (settle_cnt == 2'd2 && sync2) armed <= 1'b1;

      if (clr_ticks || tick) div_cnt <= '0;
      else                   div_cnt <= div_cnt + 1'b1;

      if (clr_ticks) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
      end

      if (at_lo)  s_lo  <= sync2;
      if (at_mid) s_mid <= sync2;
      if (shift_en) begin
        shreg   <= {vote, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      frame_error <= fe_cond;
      overrun     <= fifo_overflow;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_rx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(shreg),
    .pop      (uart_rx_fifo_read),
    .pop_data (uart_rx_fifo_data),
    .full     (uart_rx_fifo_full),
    .empty    (uart_rx_fifo_empty),
    .overflow (fifo_overflow)
  );

endmodule
